// File: rtl/sigma_bus_arb2.sv
// sigma_bus_arb2: two-master/one-slave bus arbiter, round-robin with stall lock and read-owner FIFO.
// Define SIGMA_ARB_M0_PRIO_EN for fixed priority (master 0 wins every tie).
module sigma_bus_arb2 #(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int OUTST_DEPTH = 4,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [BE_W-1:0]   m0_be,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_resp,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [BE_W-1:0]   m1_be,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_resp,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [BE_W-1:0]   s_be,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic              s_resp,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              err_o
);

  localparam int PW = $clog2(OUTST_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  state_e                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;
  logic [OUTST_DEPTH-1:0] tag_q;
  logic [PW-1:0]          wptr_q, rptr_q;
  logic [CW-1:0]          cnt_q;

  logic sel, tie, e0, e1, blk;
  logic fifo_full, fifo_empty, push, pop, head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(OUTST_DEPTH));
  // a full FIFO only blocks reads unless a response frees a slot this cycle
  assign blk        = fifo_full & ~s_resp;
  assign e0         = m0_req & ~(blk & ~m0_we);
  assign e1         = m1_req & ~(blk & ~m1_we);

`ifdef SIGMA_ARB_M0_PRIO_EN
  assign tie = 1'b0;
`else
  assign tie = ~last_q;
`endif

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (s_req) begin
      if (s_ack) begin
        state_d = IDLE;
        last_d  = sel;
      end else if (state_q == IDLE) begin
        state_d = sel ? LOCK1 : LOCK0;
      end
    end
  end

  always_comb begin
    sel   = 1'b0;
    s_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel   = (e0 & e1) ? tie : e1;
        s_req = e0 | e1;
      end
      LOCK0: begin
        sel   = 1'b0;
        s_req = e0;
      end
      LOCK1: begin
        sel   = 1'b1;
        s_req = e1;
      end
      default: ;
    endcase
    s_we    = sel ? m1_we    : m0_we;
    s_addr  = sel ? m1_addr  : m0_addr;
    s_be    = sel ? m1_be    : m0_be;
    s_wdata = sel ? m1_wdata : m0_wdata;
  end

  assign m0_ack = s_ack & s_req & ~sel;
  assign m1_ack = s_ack & s_req & sel;

  assign push     = s_req & s_ack & ~s_we;
  assign pop      = s_resp & ~fifo_empty;
  assign head     = tag_q[rptr_q];
  assign m0_resp  = pop & ~head;
  assign m1_resp  = pop & head;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign err_d    = err_q | (s_resp & fifo_empty);
  assign err_o    = err_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tag_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (push) begin
        tag_q[wptr_q] <= sel;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sigma_bus_arb2.sv
// tb_sigma_bus_arb2: directed self-checking bench for sigma_bus_arb2.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_sigma_bus_arb2;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m0_resp, m1_ack, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_ack, s_resp;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        err_o;

  int n_chk  = 0;
  int n_fail = 0;

  sigma_bus_arb2 dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_resp(m0_resp), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_resp(m1_resp), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
    .s_be(s_be), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_be = 4'hF; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_be = 4'hF; m1_wdata = '0;
    s_ack = 0; s_resp = 0; s_rdata = '0;
  endtask

  task automatic nxt();
    @(negedge clk_i);
  endtask

  task automatic smp();
    #1;
  endtask

  task automatic rd0(input logic [31:0] a);
    m0_req = 1; m0_we = 0; m0_addr = a;
  endtask

  int g;

  initial begin
    idle();
    arst_i = 1;
    nxt(); nxt(); smp();
    check("rst_sreq", s_req, 0);
    check("rst_m0ack", m0_ack, 0);
    check("rst_m1ack", m1_ack, 0);
    check("rst_m0resp", m0_resp, 0);
    check("rst_m1resp", m1_resp, 0);
    check("rst_err", err_o, 0);
    nxt(); arst_i = 0;

    // continuous write contention, s_ack always high
    nxt();
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hA0;
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hB0;
    s_ack = 1;
    for (int i = 0; i < 4; i++) begin
      smp();
`ifdef SIGMA_ARB_M0_PRIO_EN
      g = 0;
`else
      g = i % 2;
`endif
      check("rr_m0ack", m0_ack, g == 0);
      check("rr_m1ack", m1_ack, g == 1);
      check("rr_wdata", s_wdata, g ? 32'hB0 : 32'hA0);
      nxt();
    end
    idle();

    // stall lock on m1 while m0 waits
    nxt();
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h11;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        m0_req = 1; m0_we = 1; m0_addr = 32'h300; m0_wdata = 32'h22;
      end
      smp();
      check("lk_addr", s_addr, 32'h200);
      check("lk_sreq", s_req, 1);
      check("lk_m0ack", m0_ack, 0);
      check("lk_m1ack", m1_ack, 0);
      nxt();
    end
    s_ack = 1; smp();
    check("lk_addr_ack", s_addr, 32'h200);
    check("lk_m1ack_done", m1_ack, 1);
    check("lk_m0ack_wait", m0_ack, 0);
    nxt(); m1_req = 0; smp();
    check("lk_m0_next", m0_ack, 1);
    check("lk_m0_addr", s_addr, 32'h300);
    nxt(); idle();

    // single read with response two cycles later
    rd0(32'h100); s_ack = 1; smp();
    check("rd_m0ack", m0_ack, 1);
    check("rd_addr", s_addr, 32'h100);
    check("rd_swe", s_we, 0);
    nxt(); idle(); smp();
    check("rd_m0resp_c1", m0_resp, 0);
    check("rd_m1resp_c1", m1_resp, 0);
    nxt(); s_resp = 1; s_rdata = 32'hDEADBEEF; smp();
    check("rd_m0resp", m0_resp, 1);
    check("rd_m0rdata", m0_rdata, 32'hDEADBEEF);
    check("rd_m1resp", m1_resp, 0);
    nxt(); idle();

    // interleaved reads m0, m1, m0
    rd0(32'h40); s_ack = 1; smp();
    check("il_ack0", m0_ack, 1);
    nxt(); m0_req = 0;
    m1_req = 1; m1_we = 0; m1_addr = 32'h44; smp();
    check("il_ack1", m1_ack, 1);
    nxt(); m1_req = 0; rd0(32'h48); smp();
    check("il_ack2", m0_ack, 1);
    nxt(); idle();
    for (int i = 0; i < 3; i++) begin
      s_resp = 1; s_rdata = 32'(i + 1); smp();
      check("il_m0resp", m0_resp, i != 1);
      check("il_m1resp", m1_resp, i == 1);
      check("il_rdata", (i == 1) ? m1_rdata : m0_rdata, 32'(i + 1));
      nxt();
    end
    idle();

    // fill the owner FIFO with four m0 reads
    for (int i = 0; i < 4; i++) begin
      rd0(32'h80 + 32'(i)); s_ack = 1; smp();
      check("ff_fill_ack", m0_ack, 1);
      nxt();
    end
    rd0(32'h500); smp();
    check("ff_blk_sreq", s_req, 0);
    check("ff_blk_ack", m0_ack, 0);
    nxt();
    m1_req = 1; m1_we = 1; m1_addr = 32'h600; smp();
    check("ff_wr_ack", m1_ack, 1);
    check("ff_wr_swe", s_we, 1);
    check("ff_rd_wait", m0_ack, 0);
    nxt(); m1_req = 0; s_resp = 1; s_rdata = 32'h55; smp();
    check("ff_swap_sreq", s_req, 1);
    check("ff_swap_ack", m0_ack, 1);
    check("ff_swap_resp", m0_resp, 1);
    check("ff_swap_m1resp", m1_resp, 0);
    nxt(); s_resp = 0; rd0(32'h700); smp();
    check("ff_still_full", s_req, 0);
    nxt(); m0_req = 0;
    for (int i = 0; i < 4; i++) begin
      s_resp = 1; smp();
      check("ff_drain", m0_resp, 1);
      nxt();
    end
    s_resp = 1; smp();
    check("ff_empty_resp", m0_resp, 0);
    nxt(); idle(); arst_i = 1;
    nxt(); arst_i = 0;

    // reset mid-flight then a stray response
    m1_req = 1; m1_we = 0; m1_addr = 32'h900; s_ack = 1; smp();
    check("rs_m1ack", m1_ack, 1);
    nxt(); idle(); arst_i = 1;
    nxt(); arst_i = 0; smp();
    check("rs_err0", err_o, 0);
    nxt(); s_resp = 1; s_rdata = 32'h77; smp();
    check("sp_m0resp", m0_resp, 0);
    check("sp_m1resp", m1_resp, 0);
    nxt(); s_resp = 0; smp();
    check("sp_err", err_o, 1);
    nxt(); nxt(); smp();
    check("sp_err_sticky", err_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sigma_bus_arb2.md
# sigma_bus_arb2

Two-master, one-slave arbiter for the sigma SoC's internal memory/peripheral bus. It shares one slave port (on-chip RAM plus the IO bridge) between the CPU data port (master 0) and the debug/UDM host port (master 1). It serialises requests with round-robin grant and holds the grant while a request is stalled. It tracks outstanding reads in an in-order owner FIFO so each read response returns to its issuer.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. `BE_W` = `DATA_W`/8.
- `OUTST_DEPTH`, default 4: maximum outstanding reads. Must be a power of two, ≥2.

Ports:
- `clk_i`  in  1  system clock; all state on rising edge.
- `arst_i`  in  1  asynchronous, active-high reset.
- `mN_req`  in  1  master N (N=0,1) request valid.
- `mN_we`  in  1  1 = write, 0 = read.
- `mN_addr`  in  ADDR_W  request address.
- `mN_be`  in  BE_W  byte enables.
- `mN_wdata`  in  DATA_W  write data.
- `mN_ack`  out  1  request accepted this cycle.
- `mN_resp`  out  1  read data valid this cycle.
- `mN_rdata`  out  DATA_W  read data.
- `s_req`, `s_we`, `s_addr`, `s_be`, `s_wdata`  out  (as master)  request to the slave.
- `s_ack`  in  1  slave accepted the request.
- `s_resp`  in  1  slave read data valid.
- `s_rdata`  in  DATA_W  slave read data.
- `err_o`  out  1  sticky: a response arrived with no read outstanding.

## Operation
- Handshake:
  - A master holds req and its fields stable until ack.
  - A transfer completes in a cycle where s_req and s_ack are both high.
  - Writes have no response. Each read produces exactly one s_resp, in issue order.
- Grant state machine:
  - IDLE: pick a master.
    - Only one requesting: grant it.
    - Both requesting: grant the one not in `last_r`.
    - Drive s_* from the chosen master combinationally.
    - If s_ack in the same cycle: stay IDLE, set `last_r` to the winner.
    - Otherwise go to LOCK0 or LOCK1 and latch the winner.
  - LOCKn: mux master n onto s_*, regardless of the other master.
    - On s_ack: go to IDLE and set `last_r`=n.
- `mN_ack` = `s_ack` AND s_req AND granted==N. The non-granted master sees ack=0.
- Owner FIFO (depth `OUTST_DEPTH`, 1-bit tag = master index):
  - Push on every accepted read.
  - Pop on `s_resp`.
  - Route `s_rdata` to `mN_rdata` for both masters (unqualified). Assert `mN_resp` only for the popped owner.
- FIFO full: s_req is forced low for read requests. Writes still pass.
  - Exception: if s_resp is high in the same cycle, a read may issue. Pop and push happen together and the count is unchanged.
- `s_resp` with the FIFO empty: no mN_resp, no pointer change, set err_o. err_o clears only on reset.
- Pointers wrap modulo `OUTST_DEPTH`. The count ranges 0..`OUTST_DEPTH`.

## Timing
- Request path is combinational (req to s_req, s_ack to mN_ack): zero added latency.
- Response path is combinational (s_resp to mN_resp).
- The grant decision is registered only through `state`/`last_r`.
- Back-to-back transfers: one per cycle when s_ack stays high.
- Under continuous contention the masters alternate every accepted transfer.
- Reset values:
  - state=IDLE, `last_r`=1 (master 0 wins the first tie), FIFO empty, err_o=0.
  - All mN_ack/mN_resp=0, s_req=0.
- Reset mid-transfer: the lock and outstanding tags are discarded. Responses arriving after reset set err_o.
- Request withdrawal in LOCK is a protocol violation and is not supported.

## Configuration
- `SIGMA_ARB_M0_PRIO_EN` defined: fixed priority. Master 0 always wins ties in IDLE and `last_r` is ignored. Locking and the FIFO are unchanged.
- `SIGMA_ARB_M0_PRIO_EN` undefined: round-robin as described.

## Test plan
- Single read, m0 addr 0x100, slave acks in cycle 0 and resps 2 cycles later with 0xDEADBEEF: m0_ack at cycle 0, m0_resp with 0xDEADBEEF at cycle 2, m1_resp stays 0.
- Both masters issue continuous writes, s_ack=1 always: grants alternate m0,m1,m0,m1 (round-robin build). The fixed-priority build grants m0 only.
- Stall lock: m1 granted with s_ack low 3 cycles while m0 also requests. s_* holds m1 fields for all 3 cycles, then m1 acked, then m0 granted.
- Interleaved reads m0,m1,m0, resps return 0x1,0x2,0x3: delivered to m0,m1,m0 respectively.
- Full FIFO with OUTST_DEPTH=4, 4 reads outstanding:
  - A 5th read gets s_req=0 and no ack.
  - A write issues and is acked.
  - In the cycle s_resp arrives, the 5th read is acked and the count stays 4.
- Spurious s_resp after reset with FIFO empty: err_o rises and stays 1, and no mN_resp is asserted.
